multi_input_debounce_param: RTL
===============================

MULTI_INPUT_DEBOUNCE_PARAM -- requirements
Module: multi_input_debounce_param

Interface
REQ-001 Parameter FCLK, default 20000000, clock frequency in Hz.
REQ-002 Parameter DEB_MS, default 1, debounce time in milliseconds.
REQ-003 Parameter N_INPUTS, default 4, number of button channels, range 1..16.
REQ-004 Parameter MUTEX_MODE, default 1:
- 1 = only all-zero or one-hot patterns are accepted.
- 0 = any pattern is accepted.
REQ-005 i_clk_mhz  input  1  sole clock; all logic on its rising edge.
REQ-006 i_rst_mhz  input  1  reset; synchronous and active-high.
REQ-007 ei_buttons  input  N_INPUTS  raw asynchronous button levels, 1 = pressed.
REQ-008 o_btns_deb  output  N_INPUTS  debounced level pattern, registered.
REQ-009 o_btns_press  output  N_INPUTS  one-clock pulse per bit on a debounced 0->1 transition.
REQ-010 o_btns_release  output  N_INPUTS  one-clock pulse per bit on a debounced 1->0 transition.
REQ-011 o_mutex_viol  output  1  high while MUTEX_MODE=1 and the synchronized pattern is not zero or one-hot.

Function
REQ-012 c_T = FCLK/1000*DEB_MS clock cycles; elaboration SHALL fail if c_T < 4.
REQ-013 Synchronizer:
- two-flop chain on ei_buttons, producing sync.
- one further register holding the previous sync value, producing prev.
REQ-014 Timer:
- width $clog2(c_T+1).
- clears on every clock where the next state differs from the present state.
- otherwise increments, saturating at c_T-1.
REQ-015 States: ST_IDLE, ST_SETTLE, ST_STABLE, ST_CHANGE; the encoding SHALL be safe, with unreachable codes returning to ST_IDLE.
REQ-016 ST_IDLE transitions:
- to ST_SETTLE when the pattern is legal (MUTEX_MODE=0, or sync is zero/one-hot).
- otherwise stays in ST_IDLE.
REQ-017 ST_SETTLE transitions:
- to ST_IDLE when sync != prev.
- to ST_STABLE when the timer reaches c_T-2 with sync == prev, capturing prev into store.
- store is thus the value held stable for c_T consecutive clocks.
REQ-018 ST_STABLE transitions:
- to ST_CHANGE when sync != store.
- otherwise stays in ST_STABLE.
REQ-019 ST_CHANGE transitions:
- back to ST_STABLE when sync == store (glitch rejected; outputs unchanged).
- to ST_IDLE when the timer reaches c_T-3 with sync != store.
REQ-020 o_btns_deb is registered:
- equals store in ST_STABLE and ST_CHANGE.
- is zero in ST_IDLE and ST_SETTLE.
REQ-021 o_btns_press and o_btns_release SHALL be computed per bit from the registered o_btns_deb and its one-clock-delayed copy.
- A bit SHALL NOT pulse for more than one clock per transition.
- Press and release SHALL NOT both be high for the same bit in the same clock.
REQ-022 Latency:
- A clean press held from ST_IDLE with prior zero input SHALL set o_btns_deb exactly c_T+4 clocks after the ei_buttons edge.
- o_btns_press SHALL pulse on the following clock.
REQ-023 Any input change lasting fewer than c_T-3 clocks while in ST_STABLE SHALL leave all outputs unchanged.
REQ-024 A pattern change from a non-zero store to a different non-zero pattern SHALL pass through a zero o_btns_deb before the new value appears.
- A release pulse for the old bits comes first.
- A press pulse for the new bits comes later.
REQ-025 o_mutex_viol is combinational from sync and is forced low when MUTEX_MODE=0.

Reset
REQ-026 While i_rst_mhz is high at a clock edge:
- state <= ST_IDLE.
- timer, prev, store, o_btns_deb and the delayed copy <= 0.
- o_btns_press and o_btns_release <= 0.
REQ-027 Reset asserted mid-operation, including in ST_STABLE with buttons held, SHALL clear outputs on the next edge without generating release pulses.
REQ-028 The synchronizer flops SHALL NOT be reset.

Verification
REQ-029 FCLK=20000, DEB_MS=1 (c_T=20), N_INPUTS=4: reset, then ei_buttons=0001 held -> o_btns_deb=0001 exactly 24 clocks after the edge; o_btns_press=0001 for one clock on the next edge.
REQ-030 Stable 0001, then a 10-clock glitch to 0000 -> o_btns_deb stays 0001; press and release stay 0.
REQ-031 Stable 0001, then 0000 held -> o_btns_release=0001 pulse once; o_btns_deb returns to 0000.
REQ-032 MUTEX_MODE=1, ei_buttons=0110 held 100 clocks -> o_mutex_viol=1, o_btns_deb=0000, no pulses; then 0100 -> o_btns_deb=0100 after c_T+4 clocks.
REQ-033 MUTEX_MODE=0, N_INPUTS=8, ei_buttons=10100101 held -> o_btns_deb=10100101 and o_btns_press=10100101 for one clock; o_mutex_viol=0.
REQ-034 Stable 0010, then i_rst_mhz high for 1 clock -> o_btns_deb=0000 next edge with no release pulse; re-debounce yields 0010 and a press pulse.

Source files
------------

// File: rtl/multi_input_debounce_param.sv
// Multi-channel push-button debouncer.
// The raw button levels pass through a two-flop synchronizer. A four-state FSM
// then accepts a pattern only after it has been stable for c_T clocks. An
// optional mutual-exclusion filter rejects any pattern that is not zero or
// one-hot. The outputs are the debounced level plus one-clock press and release
// pulses for each channel.
module multi_input_debounce_param #(
   parameter int FCLK       = 20000000,
   parameter int DEB_MS     = 1,
   parameter int N_INPUTS   = 4,
   parameter int MUTEX_MODE = 1
) (
   input  logic                i_clk_mhz,
   input  logic                i_rst_mhz,
   input  logic [N_INPUTS-1:0] ei_buttons,
   output logic [N_INPUTS-1:0] o_btns_deb,
   output logic [N_INPUTS-1:0] o_btns_press,
   output logic [N_INPUTS-1:0] o_btns_release,
   output logic                o_mutex_viol
);

   localparam int C_T = FCLK / 1000 * DEB_MS;
   localparam int TW  = $clog2(C_T + 1);

   // Timer compare points. SETTLE exits at c_T-2. The pipeline delays around
   // that point make the accepted value stable for c_T clocks in total.
   localparam logic [TW-1:0] T_SETTLE = TW'(C_T - 2);
   localparam logic [TW-1:0] T_CHANGE = TW'(C_T - 3);
   localparam logic [TW-1:0] T_MAX    = TW'(C_T - 1);

   // Stop elaboration if the parameters are out of range.
   generate
      if (C_T < 4) begin : g_bad_ct
         $error("multi_input_debounce_param: debounce period c_T must be at least 4 clocks");
      end
      if (N_INPUTS < 1 || N_INPUTS > 16) begin : g_bad_n
         $error("multi_input_debounce_param: N_INPUTS must be in 1..16");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_STABLE = 2'd2,
      ST_CHANGE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [N_INPUTS-1:0] meta_q, sync_q;
   logic [N_INPUTS-1:0] prev_q;
   logic [N_INPUTS-1:0] store_q, store_d;
   logic [N_INPUTS-1:0] deb_q, deb_dly_q;
   logic [N_INPUTS-1:0] press_q, release_q;
   logic                onehot_or_zero;
   logic                pattern_ok;

   // Two-flop synchronizer for the asynchronous button levels. It has no reset
   // so that a reset does not disturb the path from the metastable flop.
   always_ff @(posedge i_clk_mhz) begin
      meta_q <= ei_buttons;
      sync_q <= meta_q;
   end

   // Keep last clock's synchronized pattern so SETTLE can detect bouncing.
   always_ff @(posedge i_clk_mhz) begin
      if (i_rst_mhz) prev_q <= '0;
      else           prev_q <= sync_q;
   end

   // A pattern with at most one bit set has no bits left after clearing the lowest set bit.
   assign onehot_or_zero = ((sync_q & (sync_q - N_INPUTS'(1))) == '0);
   assign pattern_ok     = (MUTEX_MODE == 0) || onehot_or_zero;
   assign o_mutex_viol   = (MUTEX_MODE != 0) && !onehot_or_zero;

   // Next-state logic, store capture, and the timer that clears on every state change.
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pattern_ok) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (sync_q != prev_q) begin
               state_d = ST_IDLE;
            end else if (timer_q == T_SETTLE) begin
               state_d = ST_STABLE;
               store_d = prev_q;
            end
         end
         ST_STABLE: begin
            if (sync_q != store_q) state_d = ST_CHANGE;
         end
         ST_CHANGE: begin
            if (sync_q == store_q)       state_d = ST_STABLE;
            else if (timer_q == T_CHANGE) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q)  timer_d = '0;
      else if (timer_q != T_MAX) timer_d = timer_q + TW'(1);
      else                     timer_d = timer_q;
   end

   // FSM state, timer and accepted pattern. The debounced level is driven from
   // the present state, which gives it one register stage of delay.
   always_ff @(posedge i_clk_mhz) begin
      if (i_rst_mhz) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         store_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         store_q   <= store_d;
         deb_q     <= (state_q == ST_STABLE || state_q == ST_CHANGE) ? store_q : '0;
         deb_dly_q <= deb_q;
      end
   end

   // Edge detection on each channel. Reset clears the level and its delayed
   // copy together, so a reset never produces a release pulse.
   generate
      for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_edge
         always_ff @(posedge i_clk_mhz) begin
            if (i_rst_mhz) begin
               press_q[gi]   <= 1'b0;
               release_q[gi] <= 1'b0;
            end else begin
               press_q[gi]   <= deb_q[gi] & ~deb_dly_q[gi];
               release_q[gi] <= ~deb_q[gi] & deb_dly_q[gi];
            end
         end
      end
   endgenerate

   assign o_btns_deb     = deb_q;
   assign o_btns_press   = press_q;
   assign o_btns_release = release_q;

endmodule
